// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver: time-multiplexed common-anode 4-digit seven-segment driver.
// Captures a frame snapshot of four hex digits and scans them out with
// anti-ghosting blank cycles and optional leading-zero blanking.
module ssd_scan_driver #(
  parameter int unsigned SCAN_DIV  = 4096,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic       clk_out,
  input  logic       rst_n,
  input  logic [3:0] in0,
  input  logic [3:0] in1,
  input  logic [3:0] in2,
  input  logic [3:0] in3,
  input  logic [3:0] dp,
  input  logic       lz_en,
  input  logic       freeze,
  output logic [3:0] ssd_ctl,
  output logic [7:0] ssd_seg,
  output logic       frame_tick
);

  localparam int unsigned CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] DIV_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYC);

  logic [CW-1:0] div_cnt;
  logic [1:0]    slot;
  logic          div_wrap;
  logic          snap_edge;

  logic [3:0] s0, s1, s2, s3;
  logic [3:0] sdp;

  logic [3:0] lz_blank;
  logic [3:0] cur_val;
  logic       cur_dp;
  logic [7:0] seg_byte;
  logic [3:0] ctl_d;
  logic [7:0] seg_d;
  logic       tick_d;

  // Full active-low segment byte for a hex digit with dp off.
  function automatic logic [7:0] hex_byte(input logic [3:0] v);
    logic [7:0] b;
    case (v)
      4'h0: b = 8'h03;
      4'h1: b = 8'h9F;
      4'h2: b = 8'h25;
      4'h3: b = 8'h0D;
      4'h4: b = 8'h99;
      4'h5: b = 8'h49;
      4'h6: b = 8'h41;
      4'h7: b = 8'h1F;
      4'h8: b = 8'h01;
      4'h9: b = 8'h09;
      4'hA: b = 8'h11;
      4'hB: b = 8'hC1;
      4'hC: b = 8'h63;
      4'hD: b = 8'h85;
      4'hE: b = 8'h61;
      default: b = 8'h71;
    endcase
    return b;
  endfunction

  assign div_wrap  = (div_cnt == DIV_LAST);
  assign snap_edge = div_wrap && (slot == 2'd3);

  // Slot timer and digit index; slot advances when the divider wraps.
  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      slot    <= '0;
    end else if (div_wrap) begin
      div_cnt <= '0;
      slot    <= slot + 2'd1;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

  // Frame snapshot: inputs are sampled only on the last cycle of a frame.
  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      s0  <= '0;
      s1  <= '0;
      s2  <= '0;
      s3  <= '0;
      sdp <= '0;
    end else if (snap_edge && !freeze) begin
      s0  <= in0;
      s1  <= in1;
      s2  <= in2;
      s3  <= in3;
      sdp <= dp;
    end
  end

  // Leading-zero mask from the snapshot; lz_en acts live.
  always_comb begin
    lz_blank = '0;
    if (lz_en) begin
      lz_blank[3] = (s3 == 4'd0);
      lz_blank[2] = lz_blank[3] && (s2 == 4'd0);
      lz_blank[1] = lz_blank[2] && (s1 == 4'd0);
    end
  end

  // Select the snapshot digit for the current slot.
  always_comb begin
    cur_val = s0;
    cur_dp  = sdp[0];
    case (slot)
      2'd1: begin cur_val = s1; cur_dp = sdp[1]; end
      2'd2: begin cur_val = s2; cur_dp = sdp[2]; end
      2'd3: begin cur_val = s3; cur_dp = sdp[3]; end
      default: begin cur_val = s0; cur_dp = sdp[0]; end
    endcase
  end

  // Next output values; a blanked slot or the blank window drives all-off.
  always_comb begin
    seg_byte = hex_byte(cur_val);
    ctl_d    = '1;
    seg_d    = '1;
    tick_d   = (slot == 2'd0) && (div_cnt == '0);
    if (!((div_cnt < BLANK_LIM) || lz_blank[slot])) begin
      ctl_d[slot] = 1'b0;
      seg_d       = {seg_byte[7:1], ~cur_dp};
    end
  end

  // Registered outputs, one cycle behind the counter state.
  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      ssd_ctl    <= '1;
      ssd_seg    <= '1;
      frame_tick <= 1'b0;
    end else begin
      ssd_ctl    <= ctl_d;
      ssd_seg    <= seg_d;
      frame_tick <= tick_d;
    end
  end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Scoreboard bench for ssd_scan_driver with SCAN_DIV=8, BLANK_CYC=2 (32-clock frame).
module tb_ssd_scan_driver;

  logic       clk_out;
  logic       rst_n;
  logic [3:0] in0, in1, in2, in3;
  logic [3:0] dp;
  logic       lz_en;
  logic       freeze;
  logic [3:0] ssd_ctl;
  logic [7:0] ssd_seg;
  logic       frame_tick;

  // expected entry: {frame_tick, ssd_ctl, ssd_seg}
  logic [12:0] exp_q [$];
  int unsigned checks = 0;
  int unsigned passed = 0;
  bit          done   = 1'b0;

  ssd_scan_driver #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (
    .clk_out    (clk_out),
    .rst_n      (rst_n),
    .in0        (in0),
    .in1        (in1),
    .in2        (in2),
    .in3        (in3),
    .dp         (dp),
    .lz_en      (lz_en),
    .freeze     (freeze),
    .ssd_ctl    (ssd_ctl),
    .ssd_seg    (ssd_seg),
    .frame_tick (frame_tick)
  );

  initial begin
    clk_out = 1'b0;
    forever #5 clk_out = ~clk_out;
  end

  // Queue n cycles of one frame's expected outputs; lit[k]=0 means slot k blanked.
  task automatic push_frame(input logic [7:0] d3, input logic [7:0] d2,
                            input logic [7:0] d1, input logic [7:0] d0,
                            input logic [3:0] lit, input int unsigned n);
    logic [7:0]  segs [4];
    logic [3:0]  ctl;
    int unsigned k;
    int unsigned c;
    segs[0] = d0; segs[1] = d1; segs[2] = d2; segs[3] = d3;
    for (int unsigned i = 0; i < n; i++) begin
      k = i / 8;
      c = i % 8;
      if (c < 2 || !lit[k]) begin
        exp_q.push_back({(i == 0), 4'b1111, 8'hFF});
      end else begin
        ctl    = 4'b1111;
        ctl[k] = 1'b0;
        exp_q.push_back({(i == 0), ctl, segs[k]});
      end
    end
  endtask

  task automatic push_reset(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) exp_q.push_back({1'b0, 4'b1111, 8'hFF});
  endtask

  task automatic set_in(input logic [3:0] a3, input logic [3:0] a2,
                        input logic [3:0] a1, input logic [3:0] a0,
                        input logic [3:0] dpv);
    in3 = a3; in2 = a2; in1 = a1; in0 = a0; dp = dpv;
  endtask

  // Stimulus: each frame pushes its expectation, then changes inputs mid-frame.
  initial begin
    rst_n = 1'b0; lz_en = 1'b0; freeze = 1'b0;
    set_in(4'd0, 4'd0, 4'd0, 4'd0, 4'b0000);
    push_reset(2);
    repeat (2) @(negedge clk_out);
    #1;
    rst_n = 1'b1;
    set_in(4'd0, 4'd1, 4'd0, 4'd1, 4'b0000);

    // F0: reset snapshot, all zeros
    push_frame(8'h03, 8'h03, 8'h03, 8'h03, 4'b1111, 32);
    repeat (32) @(negedge clk_out);

    // F1: 1,0,1,0 pattern; zeros loaded mid-frame for F2
    push_frame(8'h03, 8'h9F, 8'h03, 8'h9F, 4'b1111, 32);
    repeat (10) @(negedge clk_out);
    set_in(4'd0, 4'd0, 4'd0, 4'd0, 4'b0000);
    repeat (22) @(negedge clk_out);

    // F2: all zeros with blanking -> only digit 0
    lz_en = 1'b1;
    push_frame(8'hFF, 8'hFF, 8'hFF, 8'h03, 4'b0001, 32);
    repeat (5) @(negedge clk_out);
    set_in(4'd0, 4'd5, 4'd0, 4'd7, 4'b0000);
    repeat (27) @(negedge clk_out);

    // F3: 0,5,0,7 -> digit3 blanked; mid-frame change must not show yet
    push_frame(8'hFF, 8'h49, 8'h03, 8'h1F, 4'b0111, 32);
    repeat (10) @(negedge clk_out);
    set_in(4'd0, 4'd0, 4'd0, 4'd8, 4'b0001);
    repeat (22) @(negedge clk_out);

    // F4: 8 with dp on digit 0 -> 00; freeze across the next snapshot
    push_frame(8'hFF, 8'hFF, 8'hFF, 8'h00, 4'b0001, 32);
    repeat (10) @(negedge clk_out);
    freeze = 1'b1;
    set_in(4'd3, 4'd2, 4'd1, 4'd0, 4'b0000);
    repeat (22) @(negedge clk_out);

    // F5: frozen, old digits persist; release freeze
    push_frame(8'hFF, 8'hFF, 8'hFF, 8'h00, 4'b0001, 32);
    repeat (3) @(negedge clk_out);
    freeze = 1'b0;
    repeat (29) @(negedge clk_out);

    // F6: 3,2,1,0 appear
    push_frame(8'h0D, 8'h25, 8'h9F, 8'h03, 4'b1111, 32);
    repeat (32) @(negedge clk_out);

    // F7: reset asserted while slot2 cycle5 is on the outputs
    lz_en = 1'b0;
    push_frame(8'h0D, 8'h25, 8'h9F, 8'h03, 4'b1111, 21);
    push_reset(2);
    repeat (21) @(negedge clk_out);
    @(posedge clk_out);
    #1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk_out);
    #1;
    rst_n = 1'b1;

    // F8: restart with zero snapshot
    push_frame(8'h03, 8'h03, 8'h03, 8'h03, 4'b1111, 32);
    repeat (32) @(negedge clk_out);
    done = 1'b1;
  end

  // Monitor: compare one expected entry per falling edge; owns the summary.
  initial begin : monitor
    logic [12:0] e;
    int unsigned idle;
    int unsigned idx;
    idle = 0;
    idx  = 0;
    forever begin
      @(negedge clk_out);
      if (exp_q.size() > 0) begin
        e    = exp_q.pop_front();
        idle = 0;
        checks++;
        if ({frame_tick, ssd_ctl, ssd_seg} !== e) begin
          $display("FAIL out#%0d got tick=%b ctl=%b seg=%h, expected tick=%b ctl=%b seg=%h",
                   idx, frame_tick, ssd_ctl, ssd_seg, e[12], e[11:8], e[7:0]);
        end else begin
          passed++;
        end
        idx++;
      end else if (done) begin
        break;
      end else begin
        idle++;
        if (idle > 100) begin
          checks++;
          $display("FAIL timeout got idle=%0d cycles, expected stimulus completion", idle);
          break;
        end
      end
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ssd_scan_driver.md
# ssd_scan_driver

Reader side of the 4-digit shifter: consumes the four 4-bit digit values `in0..in3` and time-multiplexes them onto a common-anode 4-digit seven-segment display. Each frame's digits are captured atomically, so the display never tears mid-frame. Each digit is decoded as hex. The block inserts anti-ghosting blank cycles, applies optional leading-zero blanking, and emits a frame tick for the lab top level.

## Interface
Parameters:
- `SCAN_DIV`, default 4096: clocks per digit slot. Must be ≥ 2.
- `BLANK_CYC`, default 16: clocks at the start of each slot with all digits off. Must satisfy 0 ≤ `BLANK_CYC` < `SCAN_DIV`.

Ports:
- `clk_out`  in  1  clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in0`, `in1`, `in2`, `in3`  in  4 each  digit values. `in0` is the rightmost digit, `in3` the leftmost.
- `dp`  in  4  decimal-point request per digit; `dp[i]` pairs with `in<i>`; 1 = lit.
- `lz_en`  in  1  leading-zero blanking enable.
- `freeze`  in  1  1 = hold the current snapshot (no capture at frame end).
- `ssd_ctl`  out  4  digit enables, active-low; `ssd_ctl[i]` drives digit i.
- `ssd_seg`  out  8  segments `{a,b,c,d,e,f,g,dp}`, active-low.
- `frame_tick`  out  1  one-cycle pulse on the first output cycle of each frame.

## Operation
- State:
  - `div_cnt` counts 0..`SCAN_DIV`-1.
  - `slot` counts 0..3 and increments when `div_cnt` wraps.
  - Scan order is digit 0, 1, 2, 3, then repeat. One frame = 4×`SCAN_DIV` clocks.
- Snapshot registers `s0..s3`, `sdp`:
  - Load from `in0..in3` and `dp` on the edge where `slot`=3 and `div_cnt`=`SCAN_DIV`-1, unless `freeze`=1.
  - Inputs are never sampled at any other time.
- Leading-zero blanking, computed from the snapshot when `lz_en`=1:
  - Digit 3 is blanked if `s3`=0.
  - Digit 2 is blanked if `s3`=`s2`=0.
  - Digit 1 is blanked if `s3`=`s2`=`s1`=0.
  - Digit 0 is never blanked.
  - A blanked digit's `dp` is suppressed as well.
  - `lz_en` is sampled live, not snapshotted.
- Output for each state (`slot`=k, `div_cnt`=c):
  - If c < `BLANK_CYC`, or digit k is blanked: `ssd_ctl`=4'b1111, `ssd_seg`=8'hFF.
  - Otherwise: `ssd_ctl` = all ones except bit k = 0, and `ssd_seg` = `{decode(s_k), ~sdp[k]}`.
- Hex decode for `ssd_seg[7:1]`, shown as full bytes with dp=off (the low bit is then replaced by `~sdp[k]`):
  - 0→03, 1→9F, 2→25, 3→0D, 4→99, 5→49, 6→41, 7→1F
  - 8→01, 9→09, A→11, b→C1, C→63, d→85, E→61, F→71
- All outputs are registered. No combinational path from inputs to outputs.

## Timing
- Reset values:
  - `div_cnt`=0, `slot`=0.
  - `s0..s3`=0, `sdp`=0.
  - `ssd_ctl`=4'b1111, `ssd_seg`=8'hFF, `frame_tick`=0.
- Latency:
  - Outputs at edge t+1 reflect the counter state at t.
  - New input values appear on the display 1 clock after the snapshot edge, i.e. at the start of the next frame.
- `frame_tick`=1 for exactly the one cycle in which the outputs reflect `slot`=0, `div_cnt`=0. This includes the first edge after reset release.
- Wrap-around: `slot` 3→0 and `div_cnt` `SCAN_DIV`-1→0 happen on the same edge as the snapshot load.
- `freeze` is sampled only on the snapshot edge. Toggling it elsewhere has no effect.
- Reset asserted mid-frame: all state and outputs return to their reset values immediately (asynchronously). On release, scanning restarts at slot 0 and the displayed digits are zeros until the first snapshot.
- With `BLANK_CYC`=0 there are no blank cycles, and `ssd_ctl` switches directly between digits.

## Test plan
All scenarios use `SCAN_DIV`=8 and `BLANK_CYC`=2, giving a 32-clock frame.

- **Reset:** hold `rst_n`=0 → `ssd_ctl`=1111, `ssd_seg`=FF, `frame_tick`=0. Release → first edge `frame_tick`=1; first frame shows `ssd_seg`=03 on each digit during cycles 2..7 of each slot, with `ssd_ctl`=1110/1101/1011/0111 in turn.
- **Shifter reset pattern:** `in0..in3`=1,0,1,0, `dp`=0000, `lz_en`=0 → second frame: slot0 `ssd_ctl`=1110/`ssd_seg`=9F, slot1 1101/03, slot2 1011/9F, slot3 0111/03; cycles 0..1 of each slot are 1111/FF.
- **Leading-zero blanking:** `in3..in0`=0,0,0,0 with `lz_en`=1 → only slot0 drives 1110/03, all other slots 1111/FF. Then `in3..in0`=0,5,0,7 → digit3 blanked, digit2=49, digit1=03, digit0=1F.
- **Mid-frame change and dp:** change inputs at cycle 10 of a frame → display unchanged until the next frame start. Set `dp`=0001 with `in0`=8 → slot0 `ssd_seg`=00.
- **Freeze:** `freeze`=1 across the snapshot edge with new inputs → the old digits persist for the whole next frame. Release `freeze` → new digits appear the frame after.
- **Reset mid-frame:** assert `rst_n`=0 at slot2 cycle 5 → outputs go to 1111/FF immediately. On release, `frame_tick` fires on the first edge and digits read 03.
